fp_div_iter: RTL

Parametrised iterative IEEE-754 binary floating-point divider with valid/ready handshakes, round-to-nearest-even or round-toward-zero, and exception flags. It is the next generation of the pipelined double-precision divider. It replaces the single-cycle wide divide with a radix-2 restoring loop, one quotient bit per cycle, and sits between the FPU operand issue stage and the writeback arbiter. Default parameters give binary64; EXP_W=8, MAN_W=23 gives binary32.

---
 rtl/fp_div_iter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring loop, one quotient bit per cycle,
// RNE/RTZ rounding, subnormals flushed to zero, valid/ready on both sides.
`timescale 1ns/1ps
module fp_div_iter #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [4:0]             flags
);

    localparam int Q  = MAN_W + 3;
    localparam int CW = $clog2(Q);
    localparam logic [EXP_W+1:0] BIAS_X   = (EXP_W+2)'(2**(EXP_W-1) - 1);
    localparam logic [EXP_W+1:0] EMAX_X   = {2'b00, {EXP_W{1'b1}}};
    localparam logic [CW-1:0]    CNT_INIT = CW'(Q - 1);

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t state, next_state;

    logic                 sign_q, rnd_q;
    logic [EXP_W-1:0]     exp_a_q, exp_b_q;
    logic [MAN_W+1:0]     rem_q;
    logic [MAN_W:0]       div_q;
    logic [Q-1:0]         quo_q;
    logic [CW-1:0]        cnt_q;

    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [MAN_W-1:0]     a_man, b_man;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in, accept;

    assign a_exp   = a[EXP_W+MAN_W-1:MAN_W];
    assign b_exp   = b[EXP_W+MAN_W-1:MAN_W];
    assign a_man   = a[MAN_W-1:0];
    assign b_man   = b[MAN_W-1:0];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (&a_exp) && (a_man == '0);
    assign b_inf   = (&b_exp) && (b_man == '0);
    assign a_nan   = (&a_exp) && (a_man != '0);
    assign b_nan   = (&b_exp) && (b_man != '0);
    assign sign_in = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
    assign accept  = in_valid && in_ready;

    // Special-operand decode, evaluated on the raw inputs so the answer is ready at accept.
    logic                 is_special;
    logic [EXP_W+MAN_W:0] spec_result;
    logic [4:0]           spec_flags;

    always_comb begin
        is_special  = 1'b1;
        spec_result = '0;
        spec_flags  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flags  = 5'b10000;
        end else if (b_zero && !a_inf) begin
            spec_result = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags  = 5'b01000;
        end else if (a_zero) begin
            spec_result = {sign_in, {(EXP_W+MAN_W){1'b0}}};
        end else if (a_inf) begin
            spec_result = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_result = {sign_in, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    // One restoring step; the remainder stays below twice the divisor so the shift never overflows.
    logic             qbit;
    logic [MAN_W+1:0] rem_sub, rem_next;

    always_comb begin
        qbit     = (rem_q >= {1'b0, div_q});
        rem_sub  = qbit ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = rem_sub << 1;
    end

    // Normalise, round and classify the finished quotient.
    logic [EXP_W+1:0]     e_base, e_norm, e_fin;
    logic [MAN_W-1:0]     mant;
    logic [MAN_W:0]       mant_inc;
    logic                 guard, sticky, inc, ovf, unf;
    logic [EXP_W+MAN_W:0] rnd_result;
    logic [4:0]           rnd_flags;

    always_comb begin
        e_base = {2'b00, exp_a_q} - {2'b00, exp_b_q} + BIAS_X;
        if (quo_q[Q-1]) begin
            mant   = quo_q[Q-2:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
            e_norm = e_base;
        end else begin
            mant   = quo_q[Q-3:1];
            guard  = quo_q[0];
            sticky = |rem_q;
            e_norm = e_base - (EXP_W+2)'(1);
        end
        inc      = !rnd_q && guard && (sticky || mant[0]);
        mant_inc = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
        e_fin    = e_norm + {{(EXP_W+1){1'b0}}, mant_inc[MAN_W]};
        ovf      = !e_fin[EXP_W+1] && (e_fin >= EMAX_X);
        unf      = e_fin[EXP_W+1] || (e_fin == '0);
        if (ovf) begin
            rnd_result = rnd_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                               : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags  = 5'b00101;
        end else if (unf) begin
            rnd_result = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            rnd_flags  = 5'b00011;
        end else begin
            rnd_result = {sign_q, e_fin[EXP_W-1:0], mant_inc[MAN_W-1:0]};
            rnd_flags  = {4'b0000, guard | sticky};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = is_special ? DONE : DIV;
            DIV:     if (cnt_q == '0) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // out_valid trails DONE entry by one cycle, so result/flags are already settled when it rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            sign_q    <= 1'b0;
            rnd_q     <= 1'b0;
            exp_a_q   <= '0;
            exp_b_q   <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q  <= sign_in;
                        rnd_q   <= rnd;
                        exp_a_q <= a_exp;
                        exp_b_q <= b_exp;
                        rem_q   <= {2'b01, a_man};
                        div_q   <= {1'b1, b_man};
                        quo_q   <= '0;
                        cnt_q   <= CNT_INIT;
                        if (is_special) begin
                            result <= spec_result;
                            flags  <= spec_flags;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_next;
                    quo_q <= {quo_q[Q-2:0], qbit};
                    cnt_q <= cnt_q - CW'(1);
                end
                ROUND: begin
                    result <= rnd_result;
                    flags  <= rnd_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
